// File: rtl/int_stim_gen_pkg.sv
// Shared types and constants for the interrupt stimulus generator.
package int_stim_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  localparam int MODE_LEVEL = 0;
  localparam int MODE_PULSE = 1;

  localparam logic [31:0] DEFAULT_ACK_ADDR = 32'h0000_7F20;

  // Byte address to word-aligned address (low two bits cleared).
  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/int_stim_gen_chan.sv
// One target channel: PC compare, arming against the fire limit, saturating fire counter.
module int_stim_chan
  import int_stim_gen_pkg::*;
#(
  parameter logic [31:0] TARGET   = 32'h0000_3000,
  parameter int          MAX_FIRE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        fire,
  output logic        hit
);

  logic armed;

  generate
    if (MAX_FIRE == 0) begin : g_unlim
      // Unlimited channels keep no history at all.
      logic unused_ok;
      assign unused_ok = &{1'b0, clk, reset, fire};
      assign armed     = 1'b1;
    end else begin : g_lim
      localparam int FC_W = $clog2(MAX_FIRE + 1);
      logic [FC_W-1:0] fires;

      always_ff @(posedge clk) begin
        if (reset) begin
          fires <= '0;
        end else if (fire && (fires != FC_W'(MAX_FIRE))) begin
          fires <= fires + FC_W'(1);
        end
      end

      assign armed = (fires < FC_W'(MAX_FIRE));
    end
  endgenerate

  assign hit = armed && (word_addr(pc) == word_addr(TARGET));

endmodule

// File: rtl/int_stim_gen.sv
// Interrupt stimulus generator: fires on target PC hits, releases on ack write or after a pulse width.
// Optional level-mode ack timeout enabled by defining INT_STIM_TIMEOUT_EN.
module int_stim_gen
  import int_stim_gen_pkg::*;
#(
  parameter int                 N_CH      = 2,
  parameter logic [32*N_CH-1:0] TARGETS   = 64'h0000_3010_0000_3000,
  parameter int                 MAX_FIRE  = 1,
  parameter int                 MODE      = MODE_LEVEL,
  parameter int                 PULSE_LEN = 4,
  parameter int                 HOLDOFF   = 2,
  parameter logic [31:0]        ACK_ADDR  = DEFAULT_ACK_ADDR,
  parameter int                 TIMEOUT   = 1024,
  localparam int                SRC_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc,
  input  logic [31:0]      m_int_addr,
  input  logic [3:0]       m_int_byteen,
  output logic             interrupt,
  output logic [SRC_W-1:0] irq_src,
  output logic             busy,
  output logic [15:0]      total_fired,
  output logic             timeout_err
);

  localparam int CNT_MAX = (PULSE_LEN > HOLDOFF) ? PULSE_LEN : HOLDOFF;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [N_CH-1:0]  hit;
  logic [N_CH-1:0]  fire;
  logic             any_hit;
  logic [SRC_W-1:0] sel;
  logic             ack;
  logic             tmo_hit;
  logic             release_now;

  generate
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
      assign fire[c] = (state == ST_IDLE) && any_hit && (sel == SRC_W'(c));
      int_stim_chan #(
        .TARGET   (TARGETS[32*c +: 32]),
        .MAX_FIRE (MAX_FIRE)
      ) u_chan (
        .clk   (clk),
        .reset (reset),
        .pc    (pc),
        .fire  (fire[c]),
        .hit   (hit[c])
      );
    end
  endgenerate

  // Lowest-index hit wins.
  always_comb begin
    any_hit = 1'b0;
    sel     = '0;
    for (int c = N_CH - 1; c >= 0; c--) begin
      if (hit[c]) begin
        any_hit = 1'b1;
        sel     = SRC_W'(c);
      end
    end
  end

  assign ack = (|m_int_byteen) && (word_addr(m_int_addr) == word_addr(ACK_ADDR));

`ifdef INT_STIM_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             timeout_err_q;

  assign tmo_hit = (MODE == MODE_LEVEL) && (state == ST_ASSERT) &&
                   (tmo_cnt == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt       <= '0;
      timeout_err_q <= 1'b0;
    end else if (state != ST_ASSERT) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
      // An ack on the final cycle takes precedence over the timeout.
      if (tmo_hit && !ack) timeout_err_q <= 1'b1;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    release_now = 1'b0;
    if (state == ST_ASSERT) begin
      if (MODE == MODE_PULSE) release_now = (cnt == CNT_W'(1));
      else                    release_now = ack || tmo_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      interrupt   <= 1'b0;
      irq_src     <= '0;
      total_fired <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_hit) begin
            state       <= ST_ASSERT;
            interrupt   <= 1'b1;
            irq_src     <= sel;
            total_fired <= total_fired + 16'd1;
            cnt         <= CNT_W'(PULSE_LEN);
          end
        end
        ST_ASSERT: begin
          if (release_now) begin
            interrupt <= 1'b0;
            if (HOLDOFF == 0) begin
              state <= ST_IDLE;
            end else begin
              state <= ST_HOLDOFF;
              cnt   <= CNT_W'(HOLDOFF);
            end
          end else if (MODE == MODE_PULSE) begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_HOLDOFF: begin
          if (cnt <= CNT_W'(1)) state <= ST_IDLE;
          else                  cnt   <= cnt - CNT_W'(1);
        end
        default: begin
          state     <= ST_IDLE;
          interrupt <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_int_stim_gen.sv
// Directed bench: four differently configured generators exercised one after another.
module tb_int_stim_gen;

  logic        clk;
  logic        rst   [4];
  logic [31:0] pc    [4];
  logic [31:0] addr  [4];
  logic [3:0]  be    [4];
  logic        irq   [4];
  logic        src   [4];
  logic        bsy   [4];
  logic [15:0] tot   [4];
  logic        terr  [4];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int_stim_gen #(.TIMEOUT(8)) u0 (
    .clk(clk), .reset(rst[0]), .pc(pc[0]), .m_int_addr(addr[0]), .m_int_byteen(be[0]),
    .interrupt(irq[0]), .irq_src(src[0]), .busy(bsy[0]), .total_fired(tot[0]), .timeout_err(terr[0]));

  int_stim_gen #(.TARGETS(64'h0000_3000_0000_3000)) u1 (
    .clk(clk), .reset(rst[1]), .pc(pc[1]), .m_int_addr(addr[1]), .m_int_byteen(be[1]),
    .interrupt(irq[1]), .irq_src(src[1]), .busy(bsy[1]), .total_fired(tot[1]), .timeout_err(terr[1]));

  int_stim_gen #(.MODE(1), .PULSE_LEN(4), .HOLDOFF(2)) u2 (
    .clk(clk), .reset(rst[2]), .pc(pc[2]), .m_int_addr(addr[2]), .m_int_byteen(be[2]),
    .interrupt(irq[2]), .irq_src(src[2]), .busy(bsy[2]), .total_fired(tot[2]), .timeout_err(terr[2]));

  int_stim_gen #(.MAX_FIRE(0), .HOLDOFF(2)) u3 (
    .clk(clk), .reset(rst[3]), .pc(pc[3]), .m_int_addr(addr[3]), .m_int_byteen(be[3]),
    .interrupt(irq[3]), .irq_src(src[3]), .busy(bsy[3]), .total_fired(tot[3]), .timeout_err(terr[3]));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ack_on(input int d);
    addr[d] = 32'h0000_7F22;
    be[d]   = 4'hF;
  endtask

  task automatic ack_off(input int d);
    addr[d] = 32'h0;
    be[d]   = 4'h0;
  endtask

  initial begin
    for (int d = 0; d < 4; d++) begin
      rst[d] = 1'b1; pc[d] = 32'h0; addr[d] = 32'h0; be[d] = 4'h0;
    end
    step(); step();
    for (int d = 0; d < 4; d++) begin
      chk("rst_irq",  {31'b0, irq[d]}, 32'd0);
      chk("rst_busy", {31'b0, bsy[d]}, 32'd0);
      chk("rst_tot",  {16'b0, tot[d]}, 32'd0);
    end
    chk("rst_src",  {31'b0, src[0]},  32'd0);
    chk("rst_terr", {31'b0, terr[0]}, 32'd0);
    for (int d = 0; d < 4; d++) rst[d] = 1'b0;
    step();

    // Level fire on channel 0 and release by ack write.
    pc[0] = 32'h0000_3000; step();
    chk("t1_irq", {31'b0, irq[0]}, 32'd1);
    chk("t1_src", {31'b0, src[0]}, 32'd0);
    chk("t1_tot", {16'b0, tot[0]}, 32'd1);
    pc[0] = 32'h0000_1000; step();
    chk("t1_hold", {31'b0, irq[0]}, 32'd1);
    ack_on(0); step();
    chk("t1_drop", {31'b0, irq[0]}, 32'd0);
    chk("t1_busy_ho", {31'b0, bsy[0]}, 32'd1);
    ack_off(0); step();
    chk("t1_busy_ho2", {31'b0, bsy[0]}, 32'd1);
    step();
    chk("t1_idle", {31'b0, bsy[0]}, 32'd0);

    // Fire limit: channel 0 exhausted, channel 1 still armed (low PC bits ignored).
    pc[0] = 32'h0000_3000; step();
    chk("t2_nofire", {31'b0, irq[0]}, 32'd0);
    pc[0] = 32'h0000_3012; step();
    chk("t2_irq", {31'b0, irq[0]}, 32'd1);
    chk("t2_src", {31'b0, src[0]}, 32'd1);
    chk("t2_tot", {16'b0, tot[0]}, 32'd2);
    pc[0] = 32'h0;

    // Fresh reset, then level assertion with no ack.
    rst[0] = 1'b1; step();
    chk("t6_rst_tot", {16'b0, tot[0]}, 32'd0);
    rst[0] = 1'b0;
    pc[0] = 32'h0000_3000; step();
    chk("t6_irq", {31'b0, irq[0]}, 32'd1);
    pc[0] = 32'h0;
    for (int i = 0; i < 7; i++) step();
    chk("t6_irq_7", {31'b0, irq[0]}, 32'd1);
    step();
`ifdef INT_STIM_TIMEOUT_EN
    chk("t6_tmo_irq",  {31'b0, irq[0]},  32'd0);
    chk("t6_tmo_err",  {31'b0, terr[0]}, 32'd1);
    chk("t6_tmo_busy", {31'b0, bsy[0]},  32'd1);
    step(); step();
    pc[0] = 32'h0000_3010; step();
    chk("t6_refire", {31'b0, irq[0]}, 32'd1);
    chk("t6_src",    {31'b0, src[0]}, 32'd1);
    pc[0] = 32'h0;
`else
    chk("t6_no_tmo_irq", {31'b0, irq[0]},  32'd1);
    chk("t6_no_tmo_err", {31'b0, terr[0]}, 32'd0);
`endif
    // Reset mid-assertion clears everything at that edge.
    rst[0] = 1'b1; step();
    chk("t6_mid_irq",  {31'b0, irq[0]},  32'd0);
    chk("t6_mid_busy", {31'b0, bsy[0]},  32'd0);
    chk("t6_mid_tot",  {16'b0, tot[0]},  32'd0);
    chk("t6_mid_terr", {31'b0, terr[0]}, 32'd0);
    chk("t6_mid_src",  {31'b0, src[0]},  32'd0);
    rst[0] = 1'b0;
    pc[0] = 32'h0000_3000; step();
    chk("t6_after_irq", {31'b0, irq[0]}, 32'd1);
    chk("t6_after_tot", {16'b0, tot[0]}, 32'd1);
    pc[0] = 32'h0;

    // Both channels target the same PC: channel 0 first, channel 1 on revisit.
    pc[1] = 32'h0000_3000; step();
    chk("t3_irq", {31'b0, irq[1]}, 32'd1);
    chk("t3_src", {31'b0, src[1]}, 32'd0);
    chk("t3_tot", {16'b0, tot[1]}, 32'd1);
    pc[1] = 32'h0; ack_on(1); step();
    chk("t3_drop", {31'b0, irq[1]}, 32'd0);
    ack_off(1); step(); step();
    pc[1] = 32'h0000_3000; step();
    chk("t3_irq2", {31'b0, irq[1]}, 32'd1);
    chk("t3_src2", {31'b0, src[1]}, 32'd1);
    chk("t3_tot2", {16'b0, tot[1]}, 32'd2);
    pc[1] = 32'h0;

    // Pulse mode: four cycles high regardless of ack, then two holdoff cycles.
    pc[2] = 32'h0000_3000; step();
    chk("t4_c1", {31'b0, irq[2]}, 32'd1);
    pc[2] = 32'h0; step();
    chk("t4_c2", {31'b0, irq[2]}, 32'd1);
    ack_on(2); step();
    chk("t4_c3_ack", {31'b0, irq[2]}, 32'd1);
    ack_off(2); step();
    chk("t4_c4", {31'b0, irq[2]}, 32'd1);
    step();
    chk("t4_drop", {31'b0, irq[2]}, 32'd0);
    chk("t4_busy_ho", {31'b0, bsy[2]}, 32'd1);
    step();
    chk("t4_busy_ho2", {31'b0, bsy[2]}, 32'd1);
    step();
    chk("t4_idle", {31'b0, bsy[2]}, 32'd0);

    // Unlimited fires: ack in idle ignored, ack+hit fires, held hit refires after holdoff.
    ack_on(3); step();
    chk("t5_idle_ack", {31'b0, bsy[3]}, 32'd0);
    pc[3] = 32'h0000_3000; step();
    chk("t5_hit_wins", {31'b0, irq[3]}, 32'd1);
    chk("t5_tot1", {16'b0, tot[3]}, 32'd1);
    step();
    chk("t5_release", {31'b0, irq[3]}, 32'd0);
    ack_off(3); step();
    chk("t5_r1", {31'b0, irq[3]}, 32'd0);
    step();
    chk("t5_r2", {31'b0, irq[3]}, 32'd0);
    chk("t5_r2_busy", {31'b0, bsy[3]}, 32'd0);
    step();
    chk("t5_refire", {31'b0, irq[3]}, 32'd1);
    chk("t5_tot2", {16'b0, tot[3]}, 32'd2);
    pc[3] = 32'h0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
